// File: rtl/uart_rx_pkg.sv
// Shared UART RX constants and helpers: sample-position arithmetic and
// parameter legality for the majority-vote sampler.
package uart_rx_pkg;

  localparam int MAX_SAMPLES = 7;

  // Signed position of sample k in a window centred on 'centre'
  function automatic int sample_pos(input int centre, input int k, input int h, input int spacing);
    return centre + (k - h) * spacing;
  endfunction

  function automatic bit params_ok(input int num_samples, input int spacing);
    return (num_samples >= 1) && (num_samples <= MAX_SAMPLES) && ((num_samples % 2) == 1) &&
           (spacing >= 1) && (spacing <= 4);
  endfunction

endpackage

// File: rtl/majority_vote.sv
// Combinational vote over a running ones count plus the final sample.
module majority_vote #(
  parameter int N = 3
) (
  input  logic [2:0] ones_i,
  input  logic       new_bit_i,
  output logic       vote_o,
  output logic       unanimous_o
);

  localparam logic [3:0] HALF = 4'((N - 1) / 2);
  localparam logic [3:0] FULL = 4'(N);

  logic [3:0] total_s;

  assign total_s     = {1'b0, ones_i} + {3'b000, new_bit_i};
  assign vote_o      = (total_s > HALF);
  assign unanimous_o = (total_s == 4'd0) || (total_s == FULL);

endmodule

// File: rtl/data_sampler_mv.sv
// N-sample majority-vote bit sampler for the UART RX path. Samples are centred
// on prescale>>1, SPACING ticks apart; an ill-fitting window degrades to one sample.
module data_sampler_mv
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int NUM_SAMPLES = 3,
  parameter int SPACING     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rx_in,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] edge_count,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_flag,
  output logic                  cfg_err
);

  localparam int         POS_W    = PRESCALE_W + 3;
  localparam int         H        = (NUM_SAMPLES - 1) / 2;
  localparam logic [2:0] LAST_IDX = 3'(NUM_SAMPLES - 1);

  if (!params_ok(NUM_SAMPLES, SPACING)) begin : g_bad_params
    $error("data_sampler_mv: NUM_SAMPLES must be odd in 1..7 and SPACING in 1..4");
  end

  logic signed [POS_W-1:0] centre_s, last_legal_s, edge_s, exp_pos_s;
  logic signed [POS_W-1:0] pos_s [0:7];
  logic [2:0] ones_q, ones_d, idx_q, idx_d, base_ones_s, base_idx_s;
  logic       bit_q, bit_d, valid_q, valid_d, noise_q, noise_d, cfg_q, cfg_d;
  logic       restart_s, hit_s, final_s, vote_s, unan_s;

  assign centre_s     = $signed({4'b0000, prescale[PRESCALE_W-1:1]});
  assign last_legal_s = $signed({3'b000, prescale}) - $signed(POS_W'(1));
  assign edge_s       = $signed({3'b000, edge_count});

  // Every window position, signed and wide enough that none can wrap
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      pos_s[k] = centre_s + POS_W'(sample_pos(0, k, H, SPACING));
    end
  end

  assign cfg_d = pos_s[0][POS_W-1] || (pos_s[NUM_SAMPLES-1] > last_legal_s);

  // edge_count==0 mid-window means the counter started a new bit
  assign restart_s   = (edge_count == {PRESCALE_W{1'b0}}) && (idx_q != 3'd0);
  assign base_idx_s  = (restart_s || cfg_q) ? 3'd0 : idx_q;
  assign base_ones_s = restart_s ? 3'd0 : ones_q;
  assign exp_pos_s   = cfg_q ? centre_s : pos_s[base_idx_s];
  assign hit_s       = enable && (edge_s == exp_pos_s);
  assign final_s     = cfg_q || (base_idx_s == LAST_IDX);

  majority_vote #(.N(NUM_SAMPLES)) u_vote (
    .ones_i      (base_ones_s),
    .new_bit_i   (rx_in),
    .vote_o      (vote_s),
    .unanimous_o (unan_s)
  );

  // Capture / decision next-state
  always_comb begin
    ones_d  = ones_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    noise_d = noise_q;
    valid_d = 1'b0;
    if (!enable) begin
      ones_d = 3'd0;
      idx_d  = 3'd0;
    end else if (hit_s && final_s) begin
      bit_d   = cfg_q ? rx_in : vote_s;
      noise_d = cfg_q ? 1'b0 : !unan_s;
      valid_d = 1'b1;
      ones_d  = 3'd0;
      idx_d   = 3'd0;
    end else if (hit_s) begin
      ones_d = base_ones_s + {2'b00, rx_in};
      idx_d  = base_idx_s + 3'd1;
    end else begin
      ones_d = base_ones_s;
      idx_d  = base_idx_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q  <= 3'd0;
      idx_q   <= 3'd0;
      bit_q   <= 1'b1;
      valid_q <= 1'b0;
      noise_q <= 1'b0;
      cfg_q   <= 1'b0;
    end else begin
      ones_q  <= ones_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      noise_q <= noise_d;
      cfg_q   <= cfg_d;
    end
  end

  assign sampled_bit  = bit_q;
  assign sample_valid = valid_q;
  assign noise_flag   = noise_q;
  assign cfg_err      = cfg_q;

endmodule

// File: doc/data_sampler_mv.md
Name: data_sampler_mv

Overview:
Parametrised successor to the fixed 3-sample UART RX bit sampler. It takes N samples of the serial line, spaced evenly and centred on the bit midpoint, and resolves them by majority vote. It outputs a one-cycle valid strobe, a noise flag when the samples disagree, and a configuration-error flag when the sample window does not fit in the bit period. It sits between the RX edge/bit counter and the deserializer, start-bit check, parity check and stop-bit check in the UART RX path.

Parameters:
PRESCALE_W, 6, width of prescale and edge_count.
NUM_SAMPLES, 3, samples per bit; must be odd, range 1..7; elaboration error otherwise.
SPACING, 1, distance in edge_count ticks between adjacent samples; range 1..4.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
prescale  in  PRESCALE_W  oversampling ratio (clocks per bit); held static while enable=1.
rx_in  in  1  serial line, already synchronised upstream.
enable  in  1  sampling enable from RX FSM.
edge_count  in  PRESCALE_W  position within current bit, 0..prescale-1, supplied by the edge counter.
sampled_bit  out  1  voted bit value.
sample_valid  out  1  one-cycle strobe; sampled_bit is updated in the same cycle.
noise_flag  out  1  samples of the last voted bit were not unanimous; valid with sample_valid, held until next strobe.
cfg_err  out  1  sample window does not fit in [0, prescale-1]; registered.

Behaviour:
- Reset values (rst=1 at clock edge): sampled_bit=1 (idle line), sample_valid=0, noise_flag=0, cfg_err=0, ones count=0, sample index=0.
- centre = prescale>>1. H = (NUM_SAMPLES-1)/2.
- Sample position k = centre + (k-H)*SPACING, for k=0..NUM_SAMPLES-1.
- Positions are computed signed, PRESCALE_W+3 bits wide. No truncation is allowed.
- cfg_err is registered each cycle as (first position < 0) OR (last position > prescale-1).
- When cfg_err=1, the block degrades to a single sample at centre. noise_flag is then forced to 0.
- Capture: when enable=1 and edge_count equals the expected position of the current index, rx_in is added to the ones count and the index increments.
- Samples are taken strictly in order. A position match for any index other than the current one is ignored.
- Decision: at the clock edge where the final position is captured, the following are registered at that same edge:
  - sampled_bit <= (ones + rx_in) > H
  - noise_flag <= (ones + rx_in) not in {0, NUM_SAMPLES}
  - sample_valid <= 1
  - ones count and index cleared to 0.
- sample_valid is high for exactly the one cycle after the last-sample edge, so latency from the final sample is 1 clock. It is never high on two consecutive cycles.
- enable=0: the partial window is discarded (ones and index cleared). No strobe is issued. sampled_bit and noise_flag hold their values.
- edge_count==0 with enable=1 while index!=0: treated as a new bit. The partial window is discarded, then normal capture applies if position 0 matches.
- enable deasserted on the same edge as the final position: no capture and no strobe.
- rst mid-window: everything returns to reset values on that edge, regardless of enable.
- prescale change while enable=1 is outside the contract. Required response: no X propagation; cfg_err is re-evaluated the next cycle.

Decomposition:
- Shared package uart_rx_pkg holds:
  - constant MAX_SAMPLES=7
  - localparam helper function sample_pos(centre, k, H, SPACING) returning a signed position
  - elaboration checks for NUM_SAMPLES and SPACING.
- One natural combinational sub-module: majority_vote. Parameter N; inputs ones count and new bit; outputs vote and unanimous.

Test Plan:
1. prescale=8, N=3, SPACING=1 (positions 3,4,5), rx_in=1,0,1 -> sampled_bit=1, noise_flag=1, sample_valid pulses when edge_count=6.
2. prescale=16, N=5, SPACING=1 (positions 6..10), rx_in=0 throughout -> sampled_bit=0, noise_flag=0; exactly one strobe per 16-clock bit over 10 consecutive bits.
3. prescale=4, N=5, SPACING=2 -> cfg_err=1 one cycle after config; single sample at edge_count=2 sets sampled_bit=rx_in; noise_flag=0.
4. prescale=8, N=3: enable dropped after the sample at edge_count=4 -> no strobe, sampled_bit unchanged; next full window with samples 0,0,1 votes to 0.
5. rst asserted at edge_count=4 mid-window -> sampled_bit=1, sample_valid=0, noise_flag=0 next cycle; the next full window votes correctly.
6. Back-to-back bits at prescale=8 with alternating values 1,0,1,0 -> strobes exactly 8 clocks apart and sampled_bit follows the pattern.
